// File: rtl/gshare_bp_pkg.sv
// rtl/gshare_bp_pkg.sv - shared types and helpers for the gshare branch predictor
package gshare_bp_pkg;

    typedef struct packed {
        int unsigned VLEN;
        int unsigned INSTR_PER_FETCH;
        bit          RVC;
        bit          DebugEn;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{VLEN: 32, INSTR_PER_FETCH: 2, RVC: 1'b1, DebugEn: 1'b1};

    typedef struct packed {
        logic valid;
        logic taken;
    } bht_prediction_t;

    typedef enum logic {
        SWEEP = 1'b0,
        IDLE  = 1'b1
    } sweep_state_e;

    // Default update shape; the instantiating level normally supplies its own.
    localparam int unsigned DEF_VLEN     = 32;
    localparam int unsigned DEF_HIST_LEN = 8;

    typedef struct packed {
        logic                    valid;
        logic [DEF_VLEN-1:0]     pc;
        logic                    taken;
        logic                    mispredict;
        logic [DEF_HIST_LEN-1:0] ghr;
    } bp_update_default_t;

    localparam int unsigned MAX_CTR_BITS = 4;

    // Saturating up/down step of a counter that is ctr_bits wide (held in MAX_CTR_BITS).
    function automatic logic [MAX_CTR_BITS-1:0] sat_inc_dec(input logic [MAX_CTR_BITS-1:0] ctr,
                                                            input logic                    taken,
                                                            input int unsigned             ctr_bits);
        logic [MAX_CTR_BITS-1:0] ctr_max;
        ctr_max = MAX_CTR_BITS'((1 << ctr_bits) - 1);
        if (taken) begin
            return (ctr == ctr_max) ? ctr : ctr + 1'b1;
        end
        return (ctr == '0) ? ctr : ctr - 1'b1;
    endfunction

endpackage

// File: rtl/gshare_bp_flush_fsm.sv
// rtl/gshare_bp_flush_fsm.sv - row-sweep FSM that (re)initialises the counter table
module gshare_flush_fsm
    import gshare_bp_pkg::*;
#(
    parameter int unsigned NR_ROWS = 512,
    parameter int unsigned ROW_W   = $clog2(NR_ROWS)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    output logic             ready_o,
    output logic             sweep_we_o,
    output logic [ROW_W-1:0] sweep_row_o
);

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NR_ROWS - 1);

    sweep_state_e     state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;

    // Next state: sweep one row per cycle, a flush always restarts from row 0.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        sweep_we_o = 1'b0;
        ready_o    = 1'b0;
        case (state_q)
            SWEEP: begin
                sweep_we_o = 1'b1;
                if (flush_i) begin
                    row_d = '0;
                end else if (row_q == LAST_ROW) begin
                    row_d   = '0;
                    state_d = IDLE;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end
            IDLE: begin
                ready_o = 1'b1;
                if (flush_i) begin
                    row_d   = '0;
                    state_d = SWEEP;
                end
            end
        endcase
    end

    // State and row counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= SWEEP;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
        end
    end

    assign sweep_row_o = row_q;

endmodule

// File: rtl/gshare_bp.sv
// rtl/gshare_bp.sv - gshare conditional-branch predictor with speculative GHR
module gshare_bp
    import gshare_bp_pkg::*;
#(
    parameter cva6_cfg_t   CVA6Cfg     = cva6_cfg_empty,
    parameter type         bp_update_t = bp_update_default_t,
    parameter int unsigned NR_ENTRIES  = 1024,
    parameter int unsigned HIST_LEN    = 8,
    parameter int unsigned CTR_BITS    = 2
) (
    input  logic                                        clk_i,
    input  logic                                        rst_ni,
    input  logic                                        flush_bp_i,
    input  logic                                        debug_mode_i,
    input  logic [CVA6Cfg.VLEN-1:0]                     vpc_i,
    input  logic                                        spec_valid_i,
    input  logic                                        spec_taken_i,
    input  bp_update_t                                  bp_update_i,
    output bht_prediction_t [CVA6Cfg.INSTR_PER_FETCH-1:0] bht_prediction_o,
    output logic [HIST_LEN-1:0]                         ghr_o,
    output logic                                        ready_o,
    output logic                                        update_correct_o
);

    localparam int unsigned VLEN          = CVA6Cfg.VLEN;
    localparam int unsigned IPF           = CVA6Cfg.INSTR_PER_FETCH;
    localparam int unsigned NR_ROWS       = NR_ENTRIES / IPF;
    localparam int unsigned ROW_W         = $clog2(NR_ROWS);
    localparam int unsigned ROW_ADDR_BITS = $clog2(IPF);
    localparam int unsigned OFFSET        = CVA6Cfg.RVC ? 1 : 2;
    localparam int unsigned SLOT_W        = (ROW_ADDR_BITS > 0) ? ROW_ADDR_BITS : 1;
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(1 << (CTR_BITS - 1));

    function automatic logic [ROW_W-1:0] row_of(input logic [VLEN-1:0] pc);
        logic [VLEN-1:0] sh;
        sh = pc >> (ROW_ADDR_BITS + OFFSET);
        return sh[ROW_W-1:0];
    endfunction

    function automatic logic [SLOT_W-1:0] slot_of(input logic [VLEN-1:0] pc);
        logic [VLEN-1:0] sh;
        sh = pc >> OFFSET;
        if (ROW_ADDR_BITS == 0 || !CVA6Cfg.RVC) begin
            return '0;
        end
        return sh[SLOT_W-1:0];
    endfunction

    logic [IPF-1:0]      vld_q [NR_ROWS];
    logic [CTR_BITS-1:0] ctr_q [NR_ROWS][IPF];

    logic [HIST_LEN-1:0] ghr_q, ghr_d;
    logic                uc_q, uc_d;
    logic                sweep_we;
    logic [ROW_W-1:0]    sweep_row;
    logic [ROW_W-1:0]    pred_row, upd_row;
    logic [SLOT_W-1:0]   upd_slot;
    logic [CTR_BITS-1:0] upd_old, upd_new;
    logic                upd_acc;

    gshare_flush_fsm #(
        .NR_ROWS (NR_ROWS),
        .ROW_W   (ROW_W)
    ) i_flush_fsm (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_bp_i),
        .ready_o     (ready_o),
        .sweep_we_o  (sweep_we),
        .sweep_row_o (sweep_row)
    );

    assign pred_row = row_of(vpc_i) ^ ROW_W'(ghr_q);
    assign upd_row  = row_of(bp_update_i.pc) ^ ROW_W'(bp_update_i.ghr);
    assign upd_slot = slot_of(bp_update_i.pc);
    assign upd_acc  = bp_update_i.valid && ready_o && !(CVA6Cfg.DebugEn && debug_mode_i);
    assign upd_old  = ctr_q[upd_row][upd_slot];
    assign upd_new  = CTR_BITS'(sat_inc_dec(MAX_CTR_BITS'(upd_old), bp_update_i.taken, CTR_BITS));

    // Per-slot prediction of the indexed row; silenced until the table is initialised.
    always_comb begin
        for (int i = 0; i < IPF; i++) begin
            bht_prediction_o[i].valid = ready_o & vld_q[pred_row][i];
            bht_prediction_o[i].taken = ready_o & ctr_q[pred_row][i][CTR_BITS-1];
        end
    end

    // GHR next value: flush clears, mispredict repair beats a speculative shift.
    always_comb begin
        ghr_d = ghr_q;
        uc_d  = uc_q;
        if (flush_bp_i) begin
            ghr_d = '0;
        end else if (upd_acc && bp_update_i.mispredict) begin
            ghr_d = HIST_LEN'({bp_update_i.ghr, bp_update_i.taken});
        end else if (spec_valid_i) begin
            ghr_d = HIST_LEN'({ghr_q, spec_taken_i});
        end
        if (upd_acc) begin
            uc_d = (upd_old[CTR_BITS-1] == bp_update_i.taken);
        end
    end

    // Counter table: the sweep owns the write port while not ready, updates otherwise.
    always_ff @(posedge clk_i) begin
        if (sweep_we) begin
            vld_q[sweep_row] <= '0;
            for (int i = 0; i < IPF; i++) begin
                ctr_q[sweep_row][i] <= CTR_INIT;
            end
        end else if (upd_acc) begin
            vld_q[upd_row][upd_slot] <= 1'b1;
            ctr_q[upd_row][upd_slot] <= upd_new;
        end
    end

    // History and update-outcome registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ghr_q <= '0;
            uc_q  <= 1'b0;
        end else begin
            ghr_q <= ghr_d;
            uc_q  <= uc_d;
        end
    end

    assign ghr_o            = ghr_q;
    assign update_correct_o = uc_q;

endmodule

// File: tb/tb_gshare_bp.sv
// tb/tb_gshare_bp.sv - self-checking bench for gshare_bp against a behavioural model
module tb_gshare_bp;
    import gshare_bp_pkg::*;

    localparam cva6_cfg_t CFG = '{VLEN: 32, INSTR_PER_FETCH: 2, RVC: 1'b1, DebugEn: 1'b1};
    localparam int NR_ENTRIES = 64;
    localparam int HIST_LEN   = 4;
    localparam int CTR_BITS   = 2;
    localparam int NR_ROWS    = 32;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        taken;
        logic        mispredict;
        logic [3:0]  ghr;
    } upd_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                  flush, dbg, spec_v, spec_t;
    logic [31:0]           vpc;
    upd_t                  upd;
    bht_prediction_t [1:0] pred;
    logic [3:0]            ghr;
    logic                  ready, uc;

    gshare_bp #(
        .CVA6Cfg     (CFG),
        .bp_update_t (upd_t),
        .NR_ENTRIES  (NR_ENTRIES),
        .HIST_LEN    (HIST_LEN),
        .CTR_BITS    (CTR_BITS)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .flush_bp_i       (flush),
        .debug_mode_i     (dbg),
        .vpc_i            (vpc),
        .spec_valid_i     (spec_v),
        .spec_taken_i     (spec_t),
        .bp_update_i      (upd),
        .bht_prediction_o (pred),
        .ghr_o            (ghr),
        .ready_o          (ready),
        .update_correct_o (uc)
    );

    int checks = 0;
    int failures = 0;

    function void check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Behavioural model: counters as plain integers, readiness as a countdown.
    int m_ctr [NR_ROWS][2];
    bit m_vld [NR_ROWS][2];
    int m_ghr;
    int m_left;
    bit m_ready;
    bit m_uc;
    bit chk_en = 1'b0;

    function int mrow(logic [31:0] pc);
        return int'((pc >> 2) % NR_ROWS);
    endfunction

    function int mslot(logic [31:0] pc);
        return int'((pc >> 1) % 2);
    endfunction

    function void model_init_table();
        for (int r = 0; r < NR_ROWS; r++) begin
            for (int s = 0; s < 2; s++) begin
                m_ctr[r][s] = 2;
                m_vld[r][s] = 1'b0;
            end
        end
    endfunction

    function void model_reset();
        model_init_table();
        m_ghr   = 0;
        m_left  = NR_ROWS;
        m_ready = 1'b0;
        m_uc    = 1'b0;
    endfunction

    function void model_step();
        bit acc;
        int r, s;
        acc = upd.valid && m_ready && !dbg;
        if (acc) begin
            r = mrow(upd.pc) ^ int'(upd.ghr);
            s = mslot(upd.pc);
            m_uc = ((m_ctr[r][s] >= 2) == upd.taken);
            if (upd.taken) m_ctr[r][s] = (m_ctr[r][s] < 3) ? m_ctr[r][s] + 1 : 3;
            else           m_ctr[r][s] = (m_ctr[r][s] > 0) ? m_ctr[r][s] - 1 : 0;
            m_vld[r][s] = 1'b1;
        end
        if (flush)                        m_ghr = 0;
        else if (acc && upd.mispredict)   m_ghr = (int'(upd.ghr) * 2 + int'(upd.taken)) % 16;
        else if (spec_v)                  m_ghr = (m_ghr * 2 + int'(spec_t)) % 16;
        if (flush) begin
            model_init_table();
            m_left  = NR_ROWS;
            m_ready = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            m_ready = (m_left == 0);
        end
    endfunction

    // Compare every cycle at the falling edge, where inputs and outputs are settled.
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            int idx;
            idx = mrow(vpc) ^ m_ghr;
            check("ready", ready, m_ready);
            check("ghr", ghr, m_ghr);
            check("upd_correct", uc, m_uc);
            for (int s = 0; s < 2; s++) begin
                check($sformatf("pred_valid[%0d]", s), pred[s].valid, m_ready ? m_vld[idx][s] : 0);
                check($sformatf("pred_taken[%0d]", s), pred[s].taken, m_ready ? (m_ctr[idx][s] >= 2) : 0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        model_step();
        #2;
    endtask

    task automatic idle_inputs();
        flush  = 1'b0;
        dbg    = 1'b0;
        spec_v = 1'b0;
        spec_t = 1'b0;
        vpc    = '0;
        upd    = '0;
    endtask

    task automatic do_upd(input logic [31:0] pc, input logic tk, input logic mis, input logic [3:0] g);
        upd = '{valid: 1'b1, pc: pc, taken: tk, mispredict: mis, ghr: g};
        step();
        upd.valid = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!ready && n < 40) begin
            step();
            n++;
        end
        check(name, n, NR_ROWS);
    endtask

    initial begin
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", ready, 0);
        check("rst_uc", uc, 0);
        check("rst_ghr", ghr, 0);
        check("rst_pred0", {pred[0].valid, pred[0].taken}, 0);
        check("rst_pred1", {pred[1].valid, pred[1].taken}, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        model_reset();
        chk_en = 1'b1;
        wait_ready("ready_after_reset");

        vpc = 32'h80;
        #1;
        check("first_pred_valid", pred[0].valid, 0);
        check("first_pred_taken", pred[0].taken, 1);

        do_upd(32'h80, 1'b0, 1'b0, 4'h0); check("uc_n1", uc, 0);
        do_upd(32'h80, 1'b0, 1'b0, 4'h0); check("uc_n2", uc, 1);
        do_upd(32'h80, 1'b1, 1'b0, 4'h0); check("uc_t1", uc, 0);
        do_upd(32'h80, 1'b1, 1'b0, 4'h0); check("uc_t2", uc, 0);
        do_upd(32'h80, 1'b1, 1'b0, 4'h0); check("uc_t3", uc, 1);
        check("pred_0x80_taken", pred[0].taken, 1);
        check("pred_0x80_valid", pred[0].valid, 1);
        do_upd(32'h80, 1'b1, 1'b0, 4'h0); check("uc_sat_taken", uc, 1);
        check("pred_sat_taken", pred[0].taken, 1);
        do_upd(32'h80, 1'b0, 1'b0, 4'h0); check("uc_sat_nt", uc, 0);

        spec_v = 1'b1;
        spec_t = 1'b1; step();
        spec_t = 1'b0; step();
        spec_t = 1'b1; step();
        spec_v = 1'b0;
        check("ghr_spec_101", ghr, 4'b0101);

        spec_v = 1'b1;
        spec_t = 1'b1;
        do_upd(32'h80, 1'b0, 1'b1, 4'b0011);
        spec_v = 1'b0;
        check("ghr_repair", ghr, 4'b0110);
        check("uc_repair", uc, 0);

        dbg = 1'b1;
        do_upd(32'h200, 1'b1, 1'b1, 4'h0);
        dbg = 1'b0;
        check("dbg_ghr", ghr, 4'b0110);
        check("dbg_uc", uc, 0);

        flush = 1'b1; step(); flush = 1'b0;
        check("flush_ready_low", ready, 0);
        for (int i = 0; i < 10; i++) do_upd(32'h80, 1'b1, 1'b1, 4'h5);
        flush = 1'b1; step(); flush = 1'b0;
        upd = '{valid: 1'b1, pc: 32'h84, taken: 1'b0, mispredict: 1'b1, ghr: 4'h9};
        wait_ready("ready_after_reflush");
        upd.valid = 1'b0;
        vpc = 32'h80;
        #1;
        check("flush_ghr", ghr, 0);
        check("flush_pred_valid", pred[0].valid, 0);
        check("flush_pred_taken", pred[0].taken, 1);
        do_upd(32'h80, 1'b1, 1'b0, 4'h0);
        check("uc_after_flush", uc, 1);

        flush = 1'b1; step(); flush = 1'b0;
        spec_v = 1'b1; spec_t = 1'b1;
        step(); step();
        spec_v = 1'b0;
        check("sweep_spec_ghr", ghr, 4'b0011);
        step(); step();
        #1;
        chk_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("midsweep_rst_ghr", ghr, 0);
        check("midsweep_rst_uc", uc, 0);
        check("midsweep_rst_ready", ready, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        rst_n  = 1'b1;
        chk_en = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            flush      = ($urandom_range(0, 199) == 0);
            dbg        = ($urandom_range(0, 7) == 0);
            spec_v     = 1'($urandom);
            spec_t     = 1'($urandom);
            vpc        = $urandom & 32'hFE;
            upd.valid  = ($urandom_range(0, 2) != 0);
            upd.pc     = $urandom & 32'hFE;
            upd.taken  = ($urandom_range(0, 3) != 0);
            upd.mispredict = ($urandom_range(0, 3) == 0);
            upd.ghr    = 4'($urandom);
            step();
        end
        idle_inputs();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
